sfifo_reader: RTL and testbench

Read-side controller for the 8-bit, 64-entry synchronous FIFO. It issues single-cycle read strobes into the FIFO, accounts for the FIFO's registered-input, registered-output read latency, and captures the returning bytes into a small local buffer. It presents the bytes downstream as a valid/ready stream with no bubbles under continuous ready. It sits between the FIFO and any byte consumer, such as a serializer or a packet builder.

---
 rtl/sfifo_pkg.sv | 16 +
 rtl/sfifo_reader_buf.sv | 47 ++++
 rtl/sfifo_reader.sv | 93 +++++++++
 tb/tb_sfifo_reader.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfifo_pkg.sv
// Shared constants and types for the 8-bit x 64-entry synchronous FIFO and its read-side controller.
// The empty margin is the number of entries still present when the registered empty flag asserts.
package sfifo_pkg;

  localparam int SFIFO_DW           = 8;
  localparam int SFIFO_DEPTH        = 64;
  localparam int SFIFO_RD_LATENCY   = 2;
  localparam int SFIFO_EMPTY_MARGIN = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

endpackage

// File: rtl/sfifo_reader_buf.sv
// Circular DEPTH x DW capture buffer: push and pop in the same cycle, head_dat valid whenever count != 0.
// Zero-latency head (a push is visible one cycle later); the caller must never push when full or pop when empty.
module sfifo_reader_buf
  import sfifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = SFIFO_DW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DW-1:0]              push_dat,
  input  logic                       pop,
  output logic [$clog2(DEPTH):0]     count,
  output logic [DW-1:0]              head_dat
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Pointers are power-of-two wide, so wrap is the natural rollover.
  assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/sfifo_reader.sv
// Read-side FIFO controller: issues read strobes, tracks RD_LATENCY in-flight reads, buffers returns, streams out valid/ready.
// First byte RD_LATENCY+1 edges after the first fifo_r_en; reads stop once buffered+in-flight bytes fill the local buffer.
module sfifo_reader
  import sfifo_pkg::*;
#(
  parameter int RD_LATENCY   = SFIFO_RD_LATENCY,
  parameter int MAX_INFLIGHT = SFIFO_EMPTY_MARGIN,
  parameter int BUF_DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  output logic                fifo_r_en,
  input  logic [SFIFO_DW-1:0] fifo_dout,
  input  logic                fifo_empty,
  input  logic                fifo_underflow,
  output logic                m_valid,
  output logic [SFIFO_DW-1:0] m_data,
  input  logic                m_ready,
  output logic                busy,
  output logic                err_underflow
);

  localparam int IW = $clog2(RD_LATENCY + 1);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int SW = CW + 1;

  rd_state_t             state;
  rd_state_t             state_nxt;
  logic [RD_LATENCY-1:0] inflight_sr;
  logic [IW-1:0]         inflight;
  logic [IW-1:0]         inflight_after;
  logic [CW-1:0]         buf_count;
  logic                  cap_vld;
  logic                  pop_rdy;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + IW'(inflight_sr[i]);
  end

  // The read in the top stage returns on this edge, so only the others still count as
  // outstanding once this edge's new read is added; this keeps back-to-back reads possible.
  assign inflight_after = inflight - IW'(inflight_sr[RD_LATENCY-1]);

  assign fifo_r_en = (state == RUN) && !fifo_empty
                  && (inflight_after < IW'(MAX_INFLIGHT))
                  && (({1'b0, buf_count} + SW'(inflight)) < SW'(BUF_DEPTH));

  assign cap_vld = inflight_sr[RD_LATENCY-1];
  assign m_valid = (buf_count != '0);
  assign pop_rdy = m_valid && m_ready;
  assign busy    = (inflight != '0) || (buf_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      inflight_sr   <= '0;
      err_underflow <= 1'b0;
    end else begin
      state       <= state_nxt;
      inflight_sr <= {inflight_sr[RD_LATENCY-2:0], fifo_r_en};
      if (fifo_underflow) err_underflow <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = DRAIN;
      DRAIN: begin
        if (enable)                                      state_nxt = RUN;
        else if ((inflight == '0) && (buf_count == '0)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  sfifo_reader_buf #(
    .DEPTH (BUF_DEPTH),
    .DW    (SFIFO_DW)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (cap_vld),
    .push_dat (fifo_dout),
    .pop      (pop_rdy),
    .count    (buf_count),
    .head_dat (m_data)
  );

endmodule

// File: tb/tb_sfifo_reader.sv
// Bench for sfifo_reader: behavioural FIFO with a lagging empty flag, scoreboard of written bytes, invariant monitor.
module tb_sfifo_reader;
  import sfifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       fifo_r_en;
  logic [7:0] fifo_dout;
  logic       fifo_empty;
  logic       fifo_underflow;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic       busy;
  logic       err_underflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sfifo_reader dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .fifo_r_en      (fifo_r_en),
    .fifo_dout      (fifo_dout),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .m_valid        (m_valid),
    .m_data         (m_data),
    .m_ready        (m_ready),
    .busy           (busy),
    .err_underflow  (err_underflow)
  );

  // FIFO model: r_en is flopped, then dout is registered; empty is registered from the pre-pop count.
  logic [7:0] fq[$];
  logic [7:0] sb[$];
  logic       r_en_q;
  logic [7:0] rd_byte;
  logic [7:0] pop_tmp;
  logic       model_uf;
  logic       force_uf;

  assign fifo_underflow = model_uf | force_uf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.delete();
      r_en_q     <= 1'b0;
      rd_byte    <= 8'h00;
      fifo_dout  <= 8'h00;
      fifo_empty <= 1'b1;
      model_uf   <= 1'b0;
    end else begin
      fifo_empty <= (fq.size() <= SFIFO_EMPTY_MARGIN);
      r_en_q     <= fifo_r_en;
      if (r_en_q) fifo_dout <= rd_byte;
      if (fifo_r_en) begin
        if (fq.size() == 0) model_uf <= 1'b1;
        else begin
          pop_tmp = fq.pop_front();
          rd_byte <= pop_tmp;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted byte and watches the stream invariants.
  int         reads = 0;
  int         pops  = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] stall_dat  = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      reads      = 0;
      pops       = 0;
      stall_prev = 1'b0;
    end else begin
      if (fifo_r_en) begin
        reads++;
        check("ren_while_empty", int'(fifo_empty), 0);
      end
      check("fifo_underflow_seen", int'(model_uf), 0);
      if (stall_prev) begin
        check("stall_valid", int'(m_valid), 1);
        check("stall_data", int'(m_data), int'(stall_dat));
      end
      if (m_valid && m_ready) begin
        pops++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h, expected no byte", m_data);
        end else begin
          check("stream_data", int'(m_data), int'(sb.pop_front()));
        end
      end
      check("buffer_overflow", int'((reads - pops) <= 4), 1);
      stall_prev = m_valid && !m_ready;
      stall_dat  = m_data;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fq.push_back(8'(base + i));
      sb.push_back(8'(base + i));
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst     = 1'b1;
    enable  = 1'b0;
    m_ready = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  // Bytes not yet delivered must be exactly those still sitting in the FIFO.
  task automatic settle(input string tag);
    m_ready = 1'b1;
    tick(40);
    check({tag, "_undelivered"}, sb.size(), fq.size());
    check({tag, "_valid_idle"}, int'(m_valid), 0);
    check({tag, "_busy_idle"}, int'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int run;
    logic prev;
    logic found;

    rst      = 1'b1;
    enable   = 1'b0;
    m_ready  = 1'b0;
    force_uf = 1'b0;
    tick(3);
    check("rst_r_en", int'(fifo_r_en), 0);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_m_data", int'(m_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err_underflow), 0);
    rst = 1'b0;
    tick(1);

    // Basic drain: first-word latency and gap-free delivery.
    load(8'h10, 16);
    m_ready = 1'b1;
    enable  = 1'b1;
    found   = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = fifo_r_en;
    end
    check("first_ren_seen", int'(found), 1);
    @(negedge clk);
    check("lat_after_edge1", int'(m_valid), 0);
    @(negedge clk);
    check("lat_after_edge2", int'(m_valid), 0);
    @(negedge clk);
    check("lat_after_edge3", int'(m_valid), 1);
    run = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!(m_valid && m_ready)) break;
      run++;
    end
    check("no_gaps_run", run, 16 - fq.size());
    tick(1);
    settle("drain");
    check("drain_err", int'(err_underflow), 0);

    // Backpressure: reads stop at a full buffer, head byte held.
    do_reset();
    load(8'h10, 16);
    enable = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_r_en) n++;
    end
    check("bp_reads", n, 4);
    check("bp_valid", int'(m_valid), 1);
    check("bp_head", int'(m_data), 8'h10);
    tick(1);
    settle("bp");

    // Empty margin: reads stop inside the margin, rest delivered after more writes.
    do_reset();
    m_ready = 1'b1;
    load(8'hA0, 3);
    enable = 1'b1;
    tick(15);
    check("margin_left_in_fifo", fq.size(), 1);
    check("margin_undelivered", sb.size(), 1);
    load(8'hA3, 3);
    settle("margin");
    for (int i = 0; i < 3; i++) load(8'(8'hB0 + 8'(i * 16)), 2);
    settle("margin_more");

    // Enable drop with reads in flight.
    do_reset();
    m_ready = 1'b1;
    load(8'h30, 16);
    enable = 1'b1;
    prev   = 1'b0;
    found  = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      found = fifo_r_en && prev;
      prev  = fifo_r_en;
    end
    check("drop_pair_seen", int'(found), 1);
    @(posedge clk);
    #1;
    enable = 1'b0;
    tick(1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_r_en) n++;
    end
    check("drop_no_ren", n, 0);
    check("drop_busy", int'(busy), 0);
    check("drop_undelivered", sb.size(), fq.size());
    tick(1);
    enable = 1'b1;
    settle("reenable");

    // Reset in the middle of operation.
    do_reset();
    load(8'h60, 16);
    enable = 1'b1;
    n      = 0;
    found  = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (fifo_r_en) n++;
      found = (n == 4);
    end
    check("mid_fourth_read", int'(found), 1);
    check("mid_pre_valid", int'(m_valid), 1);
    check("mid_pre_busy", int'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", int'(m_valid), 0);
    check("mid_rst_ren", int'(fifo_r_en), 0);
    check("mid_rst_busy", int'(busy), 0);
    tick(2);
    rst     = 1'b0;
    m_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_valid) n++;
    end
    check("mid_no_stale", n, 0);
    tick(1);
    load(8'h50, 8);
    settle("post_rst");

    // Underflow observe: sticky until reset.
    for (int k = 0; k < 4; k++) begin
      tick($urandom_range(1, 3));
      load(8'($urandom_range(0, 255)), $urandom_range(3, 8));
      m_ready = 1'($urandom_range(0, 1));
      tick($urandom_range(2, 6));
      settle("random");
    end
    check("uf_before", int'(err_underflow), 0);
    force_uf = 1'b1;
    tick(1);
    force_uf = 1'b0;
    check("uf_set", int'(err_underflow), 1);
    tick(10);
    check("uf_sticky", int'(err_underflow), 1);
    do_reset();
    check("uf_cleared", int'(err_underflow), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
